pixel_replicate_upscaler: RTL and testbench

//  2x nearest-neighbour upscaler, 80x60 -> 160x120, 8-bit greyscale; inverse of the 2x2 block-average downscaler.

---
 rtl/img_pkg.sv | 37 +++
 rtl/upscale_addr_gen.sv | 28 ++
 rtl/pixel_replicate_upscaler.sv | 99 +++++++++
 tb/tb_pixel_replicate_upscaler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image geometry, FSM state encoding and shift-add helpers
// for the 2x block-average downscaler and the 2x pixel-replicate upscaler.
package img_pkg;

  localparam int IMG_WIDTH_IN   = 80;
  localparam int IMG_HEIGHT_IN  = 60;
  localparam int IMG_WIDTH_OUT  = 2 * IMG_WIDTH_IN;
  localparam int IMG_HEIGHT_OUT = 2 * IMG_HEIGHT_IN;
  localparam int IMG_SIZE_IN    = IMG_WIDTH_IN * IMG_HEIGHT_IN;
  localparam int IMG_SIZE_OUT   = IMG_WIDTH_OUT * IMG_HEIGHT_OUT;
  localparam int PIXEL_W        = 8;
  localparam int ADDR_W         = 16;

  localparam int SX_W = $clog2(IMG_WIDTH_IN);
  localparam int SY_W = $clog2(IMG_HEIGHT_IN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3,
    ST_DONE
  } state_e;

  // Row strides as shift-add constants; these must track IMG_WIDTH_IN/OUT.
  function automatic logic [ADDR_W-1:0] mul_width_in(input logic [ADDR_W-1:0] v);
    return (v << 6) + (v << 4);
  endfunction

  function automatic logic [ADDR_W-1:0] mul_width_out(input logic [ADDR_W-1:0] v);
    return (v << 7) + (v << 5);
  endfunction

endpackage

// File: rtl/upscale_addr_gen.sv
// Combinational address generator: source read address for (sx, sy) and the
// destination write address of quadrant 'quad' of its 2x2 output block.
module upscale_addr_gen
  import img_pkg::*;
(
  input  logic [SX_W-1:0]   sx,
  input  logic [SY_W-1:0]   sy,
  input  logic [1:0]        quad,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr
);

  logic [ADDR_W-1:0] sx_w;
  logic [ADDR_W-1:0] sy_w;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;

  assign sx_w = ADDR_W'(sx);
  assign sy_w = ADDR_W'(sy);

  // quad[0] selects the right column, quad[1] the lower row of the block.
  assign dx = (sx_w << 1) + ADDR_W'(quad[0]);
  assign dy = (sy_w << 1) + ADDR_W'(quad[1]);

  assign read_addr  = mul_width_in(sy_w) + sx_w;
  assign write_addr = mul_width_out(dy) + dx;

endmodule

// File: rtl/pixel_replicate_upscaler.sv
// 2x nearest-neighbour upscaler: reads each source pixel once and writes it
// to the four destination pixels of its 2x2 block, six cycles per source pixel.
module pixel_replicate_upscaler
  import img_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic [ADDR_W-1:0]  read_addr,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic [ADDR_W-1:0]  write_addr,
  output logic               write_en,
  output logic               done
);

  state_e             state_q;
  logic [SX_W-1:0]    sx_q;
  logic [SY_W-1:0]    sy_q;
  logic [1:0]         quad_q;
  logic [PIXEL_W-1:0] pix_q;

  logic last_col;
  logic last_row;

  assign last_col = (sx_q == SX_W'(IMG_WIDTH_IN - 1));
  assign last_row = (sy_q == SY_W'(IMG_HEIGHT_IN - 1));

  // NOTE: every register here is clocked state, so it is assigned with <= only;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      quad_q  <= '0;
      pix_q   <= '0;
    end else if (!enable) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      quad_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_q <= ST_RD;
        ST_RD:   state_q <= ST_CAP;
        ST_CAP: begin
          pix_q   <= pixel_in;
          quad_q  <= 2'd0;
          state_q <= ST_W0;
        end
        ST_W0: begin
          quad_q  <= 2'd1;
          state_q <= ST_W1;
        end
        ST_W1: begin
          quad_q  <= 2'd2;
          state_q <= ST_W2;
        end
        ST_W2: begin
          quad_q  <= 2'd3;
          state_q <= ST_W3;
        end
        ST_W3: begin
          quad_q <= 2'd0;
          if (last_col && last_row) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RD;
            if (last_col) begin
              sx_q <= '0;
              sy_q <= sy_q + 1'b1;
            end else begin
              sx_q <= sx_q + 1'b1;
            end
          end
        end
        // Frame finished: hold until enable drops, never restart on our own.
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  upscale_addr_gen u_addr_gen (
    .sx         (sx_q),
    .sy         (sy_q),
    .quad       (quad_q),
    .read_addr  (read_addr),
    .write_addr (write_addr)
  );

  // Outputs decode directly from registers, so an async reset clears them at once.
  assign write_en  = (state_q == ST_W0) || (state_q == ST_W1) ||
                     (state_q == ST_W2) || (state_q == ST_W3);
  assign pixel_out = write_en ? pix_q : '0;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pixel_replicate_upscaler.sv
// Bench for pixel_replicate_upscaler: source RAM model, expected-write queue
// built from the image, full destination image check, and directed corner cases.
module tb_pixel_replicate_upscaler;

  localparam int W_IN  = 80;
  localparam int H_IN  = 60;
  localparam int W_OUT = 160;
  localparam int H_OUT = 120;
  localparam int N_IN  = W_IN * H_IN;
  localparam int N_OUT = W_OUT * H_OUT;

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         ridx;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  pixel_in = 8'h00;
  logic [15:0] read_addr;
  logic [7:0]  pixel_out;
  logic [15:0] write_addr;
  logic        write_en;
  logic        done;

  logic [7:0] src [0:N_IN-1];
  logic [7:0] dst [0:N_OUT-1];
  wr_t        exp_q [$];
  wr_t        cur;

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  int cyc      = 0;
  int start_cyc;
  bit model_on = 1'b0;

  pixel_replicate_upscaler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pixel_in   (pixel_in),
    .read_addr  (read_addr),
    .pixel_out  (pixel_out),
    .write_addr (write_addr),
    .write_en   (write_en),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source RAM: one cycle read latency.
  always @(posedge clk) pixel_in <= src[read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected write stream: each source pixel in raster order, four writes.
  task automatic build_model();
    wr_t e;
    exp_q.delete();
    for (int sy = 0; sy < H_IN; sy++)
      for (int sx = 0; sx < W_IN; sx++)
        for (int q = 0; q < 4; q++) begin
          e.ridx = sy * W_IN + sx;
          e.data = src[e.ridx];
          e.addr = (2 * sy + q / 2) * W_OUT + 2 * sx + q % 2;
          exp_q.push_back(e);
        end
    for (int i = 0; i < N_OUT; i++) dst[i] = 8'hxx;
    wr_count = 0;
  endtask

  task automatic check_golden(input string nm);
    for (int dy = 0; dy < H_OUT; dy++)
      for (int dx = 0; dx < W_OUT; dx++)
        check(nm, dst[dy * W_OUT + dx], src[(dy / 2) * W_IN + dx / 2]);
  endtask

  always @(negedge clk) begin
    if (rst_n && write_en && write_addr < 16'(N_OUT)) dst[write_addr] = pixel_out;
    if (model_on && rst_n) begin
      if (write_en) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("wr_addr", write_addr, cur.addr);
          check("wr_data", pixel_out, cur.data);
          check("rd_addr_hold", read_addr, cur.ridx);
          wr_count++;
        end
      end else begin
        check("idle_pixel_out", pixel_out, 0);
      end
    end
  end

  // Waits (bounded) for the first write of a 2x2 block at a0, then checks all four.
  task automatic expect_block(input string nm, input int a0, input logic [7:0] d, input int budget);
    int  n   = 0;
    bit  hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = write_en && (write_addr == 16'(a0));
    end
    check({nm, "_found"}, hit, 1);
    if (hit) begin
      for (int q = 0; q < 4; q++) begin
        if (q > 0) @(negedge clk);
        check({nm, "_we"}, write_en, 1);
        check({nm, "_addr"}, write_addr, a0 + (q / 2) * W_OUT + q % 2);
        check({nm, "_data"}, pixel_out, d);
      end
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_seen"}, done, 1);
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) src[i] = 8'($urandom);
    src[0]    = 8'h5A;
    src[79]   = 8'h11;
    src[80]   = 8'h22;
    src[4799] = 8'hFF;

    // Reset held with enable high: everything quiet.
    rst_n  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_write_en", write_en, 0);
    check("rst_done", done, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_pixel_out", pixel_out, 0);

    enable = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_write_en", write_en, 0);
    end
    check("idle_done", done, 0);

    // First frame: literal corner cases plus the running model.
    build_model();
    model_on = 1'b1;
    enable   = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check("rd0_read_addr", read_addr, 0);
    check("rd0_write_en", write_en, 0);
    @(negedge clk);
    check("cap0_write_en", write_en, 0);
    expect_block("px0", 0, 8'h5A, 1);
    expect_block("px79", 158, 8'h11, 1000);
    expect_block("px80", 320, 8'h22, 3);
    expect_block("px4799", 19038, 8'hFF, 30000);
    @(negedge clk);
    check("done_rise", done, 1);
    check("done_write_en", write_en, 0);
    check("done_latency", cyc - start_cyc, 28800);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("done_hold", done, 1);
      check("done_no_write", write_en, 0);
    end
    check("frame1_writes", wr_count, 19200);
    check("frame1_queue_empty", exp_q.size(), 0);
    check_golden("frame1_golden");
    model_on = 1'b0;

    // Dropping enable in DONE returns to idle.
    enable = 1'b0;
    @(negedge clk);
    check("done_clear", done, 0);
    check("done_clear_we", write_en, 0);

    // Abort during W1 of src[10] (block at dx=20, dy=0).
    enable = 1'b1;
    begin
      int  n   = 0;
      bit  hit = 1'b0;
      while (!hit && n < 200) begin
        @(negedge clk);
        n++;
        hit = write_en && (write_addr == 16'd21);
      end
      check("abort_w1_found", hit, 1);
    end
    enable = 1'b0;
    @(negedge clk);
    check("abort_write_en", write_en, 0);
    check("abort_done", done, 0);
    check("abort_read_addr", read_addr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", write_en, 0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("restart_read_addr", read_addr, 0);
    @(negedge clk);
    check("restart_cap_we", write_en, 0);
    expect_block("restart_px0", 0, 8'h5A, 1);
    enable = 1'b0;
    @(negedge clk);

    // Second frame with a fresh image, interrupted by reset mid-W2 of pixel 200.
    for (int i = 0; i < N_IN; i++) src[i] = 8'($urandom);
    build_model();
    model_on = 1'b1;
    enable   = 1'b1;
    begin
      int  n   = 0;
      bit  hit = 1'b0;
      while (!hit && n < 2000) begin
        @(negedge clk);
        n++;
        hit = write_en && (write_addr == 16'd880);
      end
      check("rst_w2_found", hit, 1);
    end
    #2;
    model_on = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_write_en", write_en, 0);
    check("arst_pixel_out", pixel_out, 0);
    check("arst_read_addr", read_addr, 0);
    check("arst_write_addr", write_addr, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    build_model();
    model_on = 1'b1;
    rst_n    = 1'b1;
    wait_done("frame2", 30000);
    check("frame2_writes", wr_count, 19200);
    check("frame2_queue_empty", exp_q.size(), 0);
    check_golden("frame2_golden");
    model_on = 1'b0;
    enable   = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
